blf_frac_gen: RTL and testbench
===============================

# blf_frac_gen

Parametrised backscatter-link-frequency generator for the 6C tag digital core, successor to the fixed M + N/2 divider. It derives a fixed-point half-period divisor from the measured TRcal and DR, and emits a registered BLF square wave, a 2×BLF strobe, a 10×Tpri count for T1 timing and a programmable low-frequency tick. It is fully synchronous to one clock: strobes and enables only, no gated or derived clocks.

## Interface
- TRCAL_W, 10, width of trcal (clock ticks)
- M_W, 6, integer bits of divisor
- FRAC_W, 3, fractional bits of divisor (1..7)
- LF_DIV, 32, low-frequency tick period in clocks (even, ≥2)
- clk_1_92m  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- trcal  in  TRCAL_W  measured TRcal in clocks
- dr  in  1  divide ratio: 0 = 8, 1 = 64/3
- blc_update  in  1  one-cycle pulse, latch new divisor
- div_en  in  1  level, run request
- lf_en  in  1  level, low-frequency tick enable
- blf  out  1  BLF square wave
- half_tick  out  1  one-cycle strobe per BLF half period
- busy  out  1  generator running
- div_int  out  M_W  divisor integer part (half period, clocks)
- div_frac  out  FRAC_W  divisor fractional part
- range_err  out  1  last update clamped or saturated
- tpri_10  out  M_W+5  10×Tpri in clocks, truncated
- lf_tick  out  1  one-cycle strobe every LF_DIV clocks
- lf_clk  out  1  square wave, period LF_DIV

## Operation
- Divisor Dq = {div_int, div_frac}, unsigned Q(M_W.FRAC_W) half-period.
- On blc_update: dr=0 → Dq = (trcal·2^FRAC_W + 8) >> 4; dr=1 → Dq = (3·trcal·2^FRAC_W + 64) >> 7. Intermediates are wide enough to avoid overflow (TRCAL_W+FRAC_W+2 bits).
- Dq < 1.0 → Dq = 1.0 and range_err=1. Dq ≥ 2^M_W → Dq = all ones and range_err=1. Otherwise range_err=0. range_err holds until the next blc_update.
- tpri_10 = (20·Dq) >> FRAC_W; it is recomputed with Dq.
- Generator:
  - Interval counter plus FRAC_W-bit fraction accumulator facc.
  - At each interval start: facc_next = facc + div_frac. Interval length = div_int + carry.
  - half_tick pulses on the last clock of each interval.
  - blf toggles on each half_tick.
  - Over 2^FRAC_W intervals, the total length equals 2^FRAC_W·Dq exactly.
- Start: div_en high while idle → busy=1 next cycle. First interval starts that cycle with facc=0 and blf=0.
- Stop:
  - With div_en low, running continues until a half_tick drives blf 1→0.
  - busy clears on the following cycle; counters and facc are cleared.
  - div_en reasserted before that point → running continues seamlessly.
- Divisor change while busy: the interval in progress finishes with its old length. The new Dq applies from the next interval start. facc is not cleared.
- Low-frequency path:
  - With lf_en high, a modulo-LF_DIV counter runs. lf_clk toggles at counts 0 and LF_DIV/2. lf_tick pulses on the cycle lf_clk rises.
  - lf_en low → counter cleared, lf_clk=0, no ticks.

## Timing
- All outputs are registered.
- Reset values: blf=0, half_tick=0, busy=0, div_int=8, div_frac=0, range_err=0, tpri_10=160, lf_tick=0, lf_clk=0. Internally facc=0 and counters are 0.
- blc_update → div_int, div_frac, range_err and tpri_10 valid 1 cycle later.
- div_en rise (idle) → first half_tick after div_int + carry clocks from the busy rise.
- Dq = 1.0 → half_tick every clock; blf period is 2 clocks.
- blc_update coincident with an interval start → the old Dq is used for that interval.
- lf_en rise → first lf_tick 1 cycle later (count 0), then every LF_DIV clocks.
- rst_n low at any time → immediate return to reset values; an in-progress BLF is abandoned.

## Test plan
- trcal=128, dr=0, update, div_en=1 → Dq=8.0, tpri_10=160, range_err=0; half_tick every 8 clocks; blf period 16 clocks.
- trcal=100, dr=1 → Dq=19/8 (div_int=2, div_frac=3), tpri_10=47. Over 8 consecutive intervals, the lengths sum to 19 clocks and each is 2 or 3.
- trcal=10, dr=0 → Dq clamped to 1.0, range_err=1; half_tick every clock. trcal=1023, dr=0, M_W=5 → saturate to 31.875, range_err=1.
- Stop behaviour:
  - div_en dropped while blf=1 → exactly one more half_tick, blf ends at 0, busy low the next cycle.
  - div_en dropped while blf=0 → two more half_ticks, then stop.
  - div_en re-raised before stop → no gap in blf.
- Change Dq 8.0 → 4.0 mid-interval → the current interval completes at 8 clocks; subsequent intervals are 4 clocks.
- lf_en=1, LF_DIV=32 → lf_tick every 32 clocks, lf_clk 16 high / 16 low. Assert rst_n low mid-run → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/blf_frac_gen.sv
// blf_frac_gen -- backscatter-link-frequency generator with a fractional divisor.
//
// Builds a fixed-point half-period divisor Dq = {div_int, div_frac} from the
// measured TRcal and the divide ratio. It then produces a BLF square wave by
// chaining intervals of div_int or div_int+1 clocks. A fraction accumulator
// picks the interval lengths so that 2^FRAC_W consecutive intervals sum to
// exactly 2^FRAC_W*Dq clocks. It also produces a free-running low-frequency
// tick. Everything runs on clk_1_92m; there are no derived clocks.
//
// Ports:
//   clk_1_92m   system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   trcal       measured TRcal in clocks
//   dr          divide ratio select: 0 = 8, 1 = 64/3
//   blc_update  one-cycle pulse, latch a new divisor from trcal/dr
//   div_en      run request (level)
//   lf_en       low-frequency tick enable (level)
//   blf         BLF square wave
//   half_tick   one-cycle strobe per BLF half period (blf toggles with it)
//   busy        generator running
//   div_int     divisor integer part (half period in clocks)
//   div_frac    divisor fractional part
//   range_err   last update was clamped to 1.0 or saturated
//   tpri_10     10*Tpri in clocks, truncated
//   lf_tick     one-cycle strobe every LF_DIV clocks
//   lf_clk      square wave with period LF_DIV clocks
//
// Timing: busy rises on the edge after div_en is seen while idle. With
// interval length L, half_tick then appears L clocks after busy rose, and
// every interval length after that.
module blf_frac_gen #(
  parameter int unsigned TRCAL_W = 10,
  parameter int unsigned M_W     = 6,
  parameter int unsigned FRAC_W  = 3,
  parameter int unsigned LF_DIV  = 32
) (
  input  logic               clk_1_92m,
  input  logic               rst_n,
  input  logic [TRCAL_W-1:0] trcal,
  input  logic               dr,
  input  logic               blc_update,
  input  logic               div_en,
  input  logic               lf_en,
  output logic               blf,
  output logic               half_tick,
  output logic               busy,
  output logic [M_W-1:0]     div_int,
  output logic [FRAC_W-1:0]  div_frac,
  output logic               range_err,
  output logic [M_W+4:0]     tpri_10,
  output logic               lf_tick,
  output logic               lf_clk
);

  // Divisor width in Q(M_W.FRAC_W).
  localparam int unsigned D_W   = M_W + FRAC_W;
  // Quotient arithmetic width. It holds 3*trcal*2^FRAC_W + 64 and the
  // saturation limit 2^D_W.
  localparam int unsigned P_RAW = TRCAL_W + FRAC_W + 3;
  localparam int unsigned P_W   = (P_RAW > D_W + 1) ? P_RAW : D_W + 1;
  // An interval is div_int plus one carry clock.
  localparam int unsigned L_W   = M_W + 1;
  localparam int unsigned T_W   = M_W + 5;
  localparam int unsigned LFC_W = (LF_DIV > 2) ? $clog2(LF_DIV) : 1;

  localparam logic [P_W-1:0] ONE_Q   = P_W'(1) << FRAC_W;
  localparam logic [P_W-1:0] SAT_LIM = P_W'(1) << D_W;

  // Generator states. Bit 0 doubles as the registered busy output.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b11;

  // ---------------------------------------------------------------------
  // Divisor computation (combinational, latched on blc_update)
  // ---------------------------------------------------------------------
  logic [P_W-1:0]     trcal_x;
  logic [P_W-1:0]     num_dr0;
  logic [P_W-1:0]     num_dr1;
  logic [P_W-1:0]     quo;
  logic [D_W-1:0]     dq_new;
  logic               err_new;
  logic [D_W+4:0]     tpri_prod;
  logic [T_W-1:0]     tpri_new;

  always_comb begin
    trcal_x = P_W'(trcal) << FRAC_W;
    // dr=0: Dq = (trcal*2^F + 8) >> 4, i.e. TRcal/16 rounded to Q.F
    num_dr0 = trcal_x + P_W'(8);
    // dr=1: Dq = (3*trcal*2^F + 64) >> 7, i.e. 3*TRcal/128 rounded
    num_dr1 = trcal_x + (trcal_x << 1) + P_W'(64);
    quo     = dr ? (num_dr1 >> 7) : (num_dr0 >> 4);
  end

  always_comb begin
    dq_new  = '0;
    err_new = 1'b0;
    if (quo < ONE_Q) begin
      dq_new  = D_W'(ONE_Q);
      err_new = 1'b1;
    end else if (quo >= SAT_LIM) begin
      dq_new  = '1;
      err_new = 1'b1;
    end else begin
      dq_new  = D_W'(quo);
    end
  end

  // 10*Tpri = 20 half periods; the fractional bits are truncated.
  always_comb begin
    tpri_prod = (D_W+5)'(dq_new) * (D_W+5)'(20);
    tpri_new  = T_W'(tpri_prod >> FRAC_W);
  end

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      div_int   <= M_W'(8);
      div_frac  <= '0;
      range_err <= 1'b0;
      tpri_10   <= T_W'(160);
    end else if (blc_update) begin
      {div_int, div_frac} <= dq_new;
      range_err           <= err_new;
      tpri_10             <= tpri_new;
    end
  end

  // ---------------------------------------------------------------------
  // BLF generator
  // ---------------------------------------------------------------------
  logic [1:0]        state;
  logic [L_W-1:0]    cnt;       // clocks left in the current interval
  logic [FRAC_W-1:0] facc;
  logic [FRAC_W:0]   facc_sum;
  logic [L_W-1:0]    ivl_len;

  // Interval start: add div_frac into the accumulator. The carry out
  // stretches this interval by one clock. facc is zero while idle, so a
  // start from idle uses facc=0 with no extra logic.
  always_comb begin
    facc_sum = {1'b0, facc} + {1'b0, div_frac};
    ivl_len  = L_W'(div_int) + L_W'(facc_sum[FRAC_W]);
  end

  assign busy = state[0];

  // Interval starts happen on the edge that enters RUN and on every
  // half_tick edge. They sample div_int/div_frac as registered. A
  // blc_update on that same edge therefore affects only the next interval.
  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      facc      <= '0;
      blf       <= 1'b0;
      half_tick <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          half_tick <= 1'b0;
          blf       <= 1'b0;
          if (div_en) begin
            state <= ST_RUN;
            cnt   <= ivl_len;
            facc  <= facc_sum[FRAC_W-1:0];
          end
        end
        ST_RUN: begin
          if (cnt == L_W'(1)) begin
            half_tick <= 1'b1;
            blf       <= ~blf;
            // Stop only on the 1->0 edge of blf, so a stopped BLF always
            // ends low. If div_en returns before then, running continues.
            if (blf && !div_en) begin
              state <= ST_DRAIN;
              cnt   <= '0;
            end else begin
              cnt  <= ivl_len;
              facc <= facc_sum[FRAC_W-1:0];
            end
          end else begin
            half_tick <= 1'b0;
            cnt       <= cnt - L_W'(1);
          end
        end
        ST_DRAIN: begin
          // busy stays high for the cycle holding the final half_tick.
          state     <= ST_IDLE;
          half_tick <= 1'b0;
          blf       <= 1'b0;
          cnt       <= '0;
          facc      <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          half_tick <= 1'b0;
          blf       <= 1'b0;
          cnt       <= '0;
          facc      <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Low-frequency tick
  // ---------------------------------------------------------------------
  logic [LFC_W-1:0] lf_cnt;

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      lf_cnt  <= '0;
      lf_clk  <= 1'b0;
      lf_tick <= 1'b0;
    end else if (!lf_en) begin
      lf_cnt  <= '0;
      lf_clk  <= 1'b0;
      lf_tick <= 1'b0;
    end else begin
      lf_tick <= (lf_cnt == '0);
      if (lf_cnt == '0) begin
        lf_clk <= 1'b1;
      end else if (lf_cnt == LFC_W'(LF_DIV / 2)) begin
        lf_clk <= 1'b0;
      end
      lf_cnt <= (lf_cnt == LFC_W'(LF_DIV - 1)) ? '0 : lf_cnt + LFC_W'(1);
    end
  end

endmodule

// File: tb/tb_blf_frac_gen.sv
module tb_blf_frac_gen;

  logic        clk_1_92m = 1'b0;
  logic        rst_n     = 1'b1;
  logic [9:0]  trcal     = '0;
  logic        dr        = 1'b0;
  logic        blc_update = 1'b0;
  logic        div_en    = 1'b0;
  logic        lf_en     = 1'b0;

  logic        blf, half_tick, busy, range_err, lf_tick, lf_clk;
  logic [5:0]  div_int;
  logic [2:0]  div_frac;
  logic [10:0] tpri_10;

  logic        s_blf, s_half_tick, s_busy, s_range_err, s_lf_tick, s_lf_clk;
  logic [4:0]  s_div_int;
  logic [2:0]  s_div_frac;
  logic [9:0]  s_tpri_10;

  int checks = 0;
  int errors = 0;

  always #5 clk_1_92m = ~clk_1_92m;

  blf_frac_gen #(.TRCAL_W(10), .M_W(6), .FRAC_W(3), .LF_DIV(32)) dut (
    .clk_1_92m(clk_1_92m), .rst_n(rst_n), .trcal(trcal), .dr(dr),
    .blc_update(blc_update), .div_en(div_en), .lf_en(lf_en),
    .blf(blf), .half_tick(half_tick), .busy(busy), .div_int(div_int),
    .div_frac(div_frac), .range_err(range_err), .tpri_10(tpri_10),
    .lf_tick(lf_tick), .lf_clk(lf_clk)
  );

  blf_frac_gen #(.TRCAL_W(10), .M_W(5), .FRAC_W(3), .LF_DIV(32)) u_sat (
    .clk_1_92m(clk_1_92m), .rst_n(rst_n), .trcal(trcal), .dr(dr),
    .blc_update(blc_update), .div_en(1'b0), .lf_en(1'b0),
    .blf(s_blf), .half_tick(s_half_tick), .busy(s_busy), .div_int(s_div_int),
    .div_frac(s_div_frac), .range_err(s_range_err), .tpri_10(s_tpri_10),
    .lf_tick(s_lf_tick), .lf_clk(s_lf_clk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1_92m);
    #1;
  endtask

  // Clocks until the next half_tick; a missing tick yields 64, which no
  // expected length matches.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (half_tick !== 1'b1 && n < 64);
  endtask

  task automatic update(input logic [9:0] t, input logic d);
    trcal = t;
    dr = d;
    blc_update = 1'b1;
    step();
    blc_update = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int sum;
    int hi;
    int tks;
    int exp_len[8];
    exp_len = '{2, 2, 3, 2, 2, 3, 2, 3};

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_blf", blf, 0);
    chk("rst_half_tick", half_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_int", div_int, 8);
    chk("rst_div_frac", div_frac, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_tpri", tpri_10, 160);
    chk("rst_lf_tick", lf_tick, 0);
    chk("rst_lf_clk", lf_clk, 0);
    step();
    rst_n = 1'b1;
    step();

    // trcal=128, dr=0 -> 8.0
    update(10'd128, 1'b0);
    chk("d8_int", div_int, 8);
    chk("d8_frac", div_frac, 0);
    chk("d8_tpri", tpri_10, 160);
    chk("d8_err", range_err, 0);
    div_en = 1'b1;
    step();
    chk("d8_busy", busy, 1);
    chk("d8_blf0", blf, 0);
    wait_tick(n); chk("d8_first_len", n, 8); chk("d8_blf1", blf, 1);
    wait_tick(n); chk("d8_second_len", n, 8); chk("d8_blf2", blf, 0);

    // Stop with blf=0: two more half_ticks
    div_en = 1'b0;
    wait_tick(n); chk("stop0_len1", n, 8); chk("stop0_blf1", blf, 1); chk("stop0_busy1", busy, 1);
    wait_tick(n); chk("stop0_len2", n, 8); chk("stop0_blf2", blf, 0); chk("stop0_busy2", busy, 1);
    step();
    chk("stop0_idle", busy, 0);
    chk("stop0_tick_low", half_tick, 0);

    // Stop with blf=1: one more half_tick, then silence
    div_en = 1'b1;
    step();
    chk("stop1_busy", busy, 1);
    wait_tick(n); chk("stop1_len0", n, 8); chk("stop1_blf_hi", blf, 1);
    div_en = 1'b0;
    wait_tick(n); chk("stop1_len1", n, 8); chk("stop1_blf_lo", blf, 0); chk("stop1_busy_tick", busy, 1);
    step();
    chk("stop1_idle", busy, 0);
    tks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      tks += int'(half_tick);
    end
    chk("stop1_no_ticks", tks, 0);

    // div_en re-raised before the stopping edge: no gap
    div_en = 1'b1;
    step();
    wait_tick(n); chk("rearm_len0", n, 8); chk("rearm_blf_hi", blf, 1);
    div_en = 1'b0;
    step(); step(); step();
    div_en = 1'b1;
    wait_tick(n); chk("rearm_len1", n, 5); chk("rearm_blf_lo", blf, 0); chk("rearm_busy", busy, 1);
    wait_tick(n); chk("rearm_len2", n, 8); chk("rearm_blf_hi2", blf, 1);
    div_en = 1'b0;
    wait_tick(n); chk("rearm_len3", n, 8);
    step();
    chk("rearm_idle", busy, 0);

    // 8.0 -> 4.0 mid-interval
    div_en = 1'b1;
    step();
    step(); step(); step();
    update(10'd64, 1'b0);
    chk("d4_int", div_int, 4);
    chk("d4_tpri", tpri_10, 80);
    wait_tick(n); chk("chg_old_len", n, 4);
    wait_tick(n); chk("chg_new_len1", n, 4);
    wait_tick(n); chk("chg_new_len2", n, 4);

    // Update on the interval-start edge: that interval keeps 4.0
    step(); step(); step();
    update(10'd100, 1'b1);
    chk("coinc_tick", half_tick, 1);
    chk("frac_int", div_int, 2);
    chk("frac_frac", div_frac, 3);
    chk("frac_tpri", tpri_10, 47);
    chk("frac_err", range_err, 0);
    wait_tick(n); chk("coinc_old_len", n, 4);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      chk($sformatf("frac_len%0d", i), n, exp_len[i]);
      sum += n;
    end
    chk("frac_sum", sum, 19);
    div_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      if (blf == 1'b0) break;
    end
    step();
    chk("frac_idle", busy, 0);

    // Clamp to 1.0
    update(10'd10, 1'b0);
    chk("clamp_int", div_int, 1);
    chk("clamp_frac", div_frac, 0);
    chk("clamp_err", range_err, 1);
    chk("clamp_tpri", tpri_10, 20);
    div_en = 1'b1;
    step();
    wait_tick(n); chk("clamp_len1", n, 1); chk("clamp_blf1", blf, 1);
    wait_tick(n); chk("clamp_len2", n, 1); chk("clamp_blf2", blf, 0);
    div_en = 1'b0;
    wait_tick(n); chk("clamp_len3", n, 1);
    wait_tick(n); chk("clamp_len4", n, 1); chk("clamp_blf_end", blf, 0);
    step();
    chk("clamp_idle", busy, 0);
    chk("clamp_err_hold", range_err, 1);

    // Saturation: M_W=6 -> 63.875, M_W=5 -> 31.875
    update(10'd1023, 1'b0);
    chk("sat6_int", div_int, 63);
    chk("sat6_frac", div_frac, 7);
    chk("sat6_err", range_err, 1);
    chk("sat6_tpri", tpri_10, 1277);
    chk("sat5_int", s_div_int, 31);
    chk("sat5_frac", s_div_frac, 7);
    chk("sat5_err", s_range_err, 1);
    chk("sat5_tpri", s_tpri_10, 637);

    // dr=1, trcal=1023 -> 24.0, range_err cleared
    update(10'd1023, 1'b1);
    chk("d24_int", div_int, 24);
    chk("d24_frac", div_frac, 0);
    chk("d24_err", range_err, 0);
    chk("d24_tpri", tpri_10, 480);

    // Low-frequency tick
    lf_en = 1'b1;
    step();
    chk("lf_first_tick", lf_tick, 1);
    chk("lf_first_clk", lf_clk, 1);
    hi = 0;
    tks = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      hi += int'(lf_clk);
      tks += int'(lf_tick);
    end
    chk("lf_period_tick", lf_tick, 1);
    chk("lf_high_count", hi, 16);
    chk("lf_tick_count", tks, 1);
    lf_en = 1'b0;
    step();
    chk("lf_off_clk", lf_clk, 0);
    chk("lf_off_tick", lf_tick, 0);

    // Asynchronous reset mid-run
    lf_en = 1'b1;
    div_en = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("mid_busy", busy, 1);
    chk("mid_blf", blf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_blf", blf, 0);
    chk("arst_half_tick", half_tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_div_int", div_int, 8);
    chk("arst_div_frac", div_frac, 0);
    chk("arst_range_err", range_err, 0);
    chk("arst_tpri", tpri_10, 160);
    chk("arst_lf_tick", lf_tick, 0);
    chk("arst_lf_clk", lf_clk, 0);
    div_en = 1'b0;
    lf_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
